md_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the EX stage. It executes the operation selected by the 3-bit ALU_MD_ctrl code that EX control decodes from the E-stage instruction.
- Holds the architectural HI/LO registers and returns HI or LO for mfhi/mflo on the AO_M path.
- Exports a stall request so hazard logic freezes F/D while an operation is in flight.

---
 rtl/md_if.sv | 24 ++
 rtl/md_unit.sv | 115 +++++++++++
 tb/tb_md_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/md_if.sv
// md_if: EX-stage multiply/divide bus. It groups the operation request (start, ctrl, operands)
// with the unit's status and result outputs (busy, md_stall, MD_out, HI, LO).
// master = EX control / hazard side (drives the request); slave = md_unit.
interface md_if;
  logic        start;
  logic [2:0]  ALU_MD_ctrl;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        md_stall;
  logic [31:0] MD_out;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, ALU_MD_ctrl, A, B,
    input  busy, md_stall, MD_out, HI, LO
  );

  modport slave (
    input  start, ALU_MD_ctrl, A, B,
    output busy, md_stall, MD_out, HI, LO
  );
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle mult/multu/div/divu unit holding the architectural HI/LO registers.
// Latency: busy for MUL_CYCLES or DIV_CYCLES; HI/LO are written on the edge that drops busy.
// Backpressure: md_stall requests a F/D freeze; a start seen while busy is ignored.
// Ports: clk_i, reset_i (sync, active-high), md (md_if.slave: start/ALU_MD_ctrl/A/B in;
//        busy/md_stall/MD_out/HI/LO out).
module md_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic clk_i,
  input  logic reset_i,
  md_if.slave  md
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;

  state_t      state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, lo_q;

  // Result datapath, evaluated from the latched operands.
  logic [31:0] hi_d, lo_d;
  logic [63:0] prod_s, prod_u;
  logic [31:0] div_b_safe, a_mag, b_mag, q_mag, r_mag, qu, ru;
  logic        div_by_zero, done, accept;

  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'b0, a_q} * {32'b0, b_q};

    // Substitute a divisor of 1 on divide-by-zero so the dividers never see 0;
    // the result is discarded in that case anyway.
    div_by_zero = (b_q == 32'd0);
    div_b_safe  = div_by_zero ? 32'd1 : b_q;
    qu          = a_q / div_b_safe;
    ru          = a_q % div_b_safe;

    // Signed divide via magnitudes: quotient truncates toward zero, remainder takes
    // the dividend's sign. 0x80000000 / -1 falls out as 0x80000000 rem 0.
    a_mag = a_q[31] ? (32'd0 - a_q) : a_q;
    b_mag = b_q[31] ? (32'd0 - div_b_safe) : div_b_safe;
    q_mag = a_mag / b_mag;
    r_mag = a_mag % b_mag;

    hi_d = hi_q;
    lo_d = lo_q;
    unique case (op_q)
      OP_MULT:  {hi_d, lo_d} = prod_s;
      OP_MULTU: {hi_d, lo_d} = prod_u;
      OP_DIV: begin
        lo_d = (a_q[31] ^ b_q[31]) ? (32'd0 - q_mag) : q_mag;
        hi_d = a_q[31] ? (32'd0 - r_mag) : r_mag;
      end
      default: begin
        lo_d = qu;
        hi_d = ru;
      end
    endcase
  end

  assign accept = (state_q == S_IDLE) && md.start && !md.ALU_MD_ctrl[2];
  assign done   = (state_q == S_BUSY) && (cnt_q == CW'(1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 2'b00;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q <= S_BUSY;
            op_q    <= md.ALU_MD_ctrl[1:0];
            a_q     <= md.A;
            b_q     <= md.B;
            cnt_q   <= md.ALU_MD_ctrl[1] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
          end
        end
        default: begin
          cnt_q <= cnt_q - CW'(1);
          if (done) begin
            state_q <= S_IDLE;
            // Divide by zero consumes the full latency but leaves HI/LO untouched.
            if (!(op_q[1] && div_by_zero)) begin
              hi_q <= hi_d;
              lo_q <= lo_d;
            end
          end
        end
      endcase
    end
  end

  assign md.busy     = (state_q == S_BUSY);
  assign md.md_stall = md.busy | (md.start & ~md.busy);
  assign md.HI       = hi_q;
  assign md.LO       = lo_q;
  assign md.MD_out   = (md.ALU_MD_ctrl == 3'b100) ? hi_q :
                       (md.ALU_MD_ctrl == 3'b101) ? lo_q : 32'd0;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed-vector bench for md_unit with hand-computed HI/LO results,
// busy-length checks, divide-by-zero, overflow divide, reset abort and back-to-back issue.
module tb_md_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [31:0] m_hi, m_lo;

  md_if mif();

  md_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .md      (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation in the current (busy=0) cycle and follow it to completion.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n_exp, input logic [31:0] hi_exp, input logic [31:0] lo_exp,
                        input string tag);
    int n;
    mif.ALU_MD_ctrl = op;
    mif.A           = a;
    mif.B           = b;
    mif.start       = 1'b1;
    #1;
    check_eq({tag, "_idle_at_start"}, mif.busy, 1'b0);
    check_eq({tag, "_stall_start"}, mif.md_stall, 1'b1);
    @(posedge clk); #1;
    mif.start = 1'b0;
    n = 0;
    while (mif.busy === 1'b1 && n < 100) begin
      if (n == 0) begin
        mif.ALU_MD_ctrl = 3'b101;
        #1;
        check_eq({tag, "_old_lo_read"}, mif.MD_out, m_lo);
        check_eq({tag, "_old_hi_reg"}, mif.HI, m_hi);
      end
      if (n == n_exp - 1) check_eq({tag, "_stall_last_busy"}, mif.md_stall, 1'b1);
      n++;
      @(posedge clk); #1;
    end
    check_eq({tag, "_busy_cycles"}, n, n_exp);
    check_eq({tag, "_HI"}, mif.HI, hi_exp);
    check_eq({tag, "_LO"}, mif.LO, lo_exp);
    m_hi = hi_exp;
    m_lo = lo_exp;
    mif.ALU_MD_ctrl = 3'b100;
    #1;
    check_eq({tag, "_mfhi"}, mif.MD_out, hi_exp);
    mif.ALU_MD_ctrl = 3'b101;
    #1;
    check_eq({tag, "_mflo"}, mif.MD_out, lo_exp);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_hi     = 32'd0;
    m_lo     = 32'd0;
    reset           = 1'b1;
    mif.start       = 1'b0;
    mif.ALU_MD_ctrl = 3'b000;
    mif.A           = 32'd0;
    mif.B           = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset state
    check_eq("rst_busy", mif.busy, 1'b0);
    check_eq("rst_stall", mif.md_stall, 1'b0);
    check_eq("rst_HI", mif.HI, 32'd0);
    check_eq("rst_LO", mif.LO, 32'd0);
    mif.ALU_MD_ctrl = 3'b100; #1;
    check_eq("rst_mfhi", mif.MD_out, 32'd0);
    mif.ALU_MD_ctrl = 3'b101; #1;
    check_eq("rst_mflo", mif.MD_out, 32'd0);

    // Multiplies: -2 * 3
    run_op(3'b000, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
    run_op(3'b001, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA, "multu");

    // Divides
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    run_op(3'b011, 32'd7, 32'd2, 10, 32'd1, 32'd3, "divu");

    // Preload HI=0x11, LO=0x22 (0x2211 / 0x100), then divide by zero
    run_op(3'b011, 32'h0000_2211, 32'h0000_0100, 10, 32'h11, 32'h22, "preload");
    run_op(3'b010, 32'd1234, 32'd0, 10, 32'h11, 32'h22, "div_by_0");
    run_op(3'b011, 32'd1234, 32'd0, 10, 32'h11, 32'h22, "divu_by_0");
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, "div_ovf");

    // Reserved / read-only ctrl codes do not start an operation
    mif.ALU_MD_ctrl = 3'b110;
    mif.A = 32'd5; mif.B = 32'd5;
    mif.start = 1'b1;
    @(posedge clk); #1;
    mif.start = 1'b0;
    check_eq("rsvd_no_busy", mif.busy, 1'b0);
    mif.ALU_MD_ctrl = 3'b111; #1;
    check_eq("rsvd_mdout_zero", mif.MD_out, 32'd0);
    mif.ALU_MD_ctrl = 3'b100;
    mif.start = 1'b1;
    @(posedge clk); #1;
    mif.start = 1'b0;
    check_eq("mfhi_start_no_busy", mif.busy, 1'b0);
    check_eq("rsvd_LO_kept", mif.LO, 32'h8000_0000);

    // Reset aborts an in-flight mult; a start while busy is ignored
    mif.ALU_MD_ctrl = 3'b000;
    mif.A = 32'd100; mif.B = 32'd100;
    mif.start = 1'b1;
    @(posedge clk); #1;              // busy cycle 1
    mif.start = 1'b0;
    check_eq("abort_busy_c1", mif.busy, 1'b1);
    @(posedge clk); #1;              // busy cycle 2
    mif.ALU_MD_ctrl = 3'b011;
    mif.A = 32'd9; mif.B = 32'd2;
    mif.start = 1'b1;
    @(posedge clk); #1;              // busy cycle 3
    mif.start = 1'b0;
    check_eq("abort_busy_c3", mif.busy, 1'b1);
    check_eq("abort_no_early_LO", mif.LO, 32'h8000_0000);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("abort_busy_rst", mif.busy, 1'b0);
    check_eq("abort_HI_rst", mif.HI, 32'd0);
    check_eq("abort_LO_rst", mif.LO, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    check_eq("abort_busy_later", mif.busy, 1'b0);
    check_eq("abort_HI_later", mif.HI, 32'd0);
    check_eq("abort_LO_later", mif.LO, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;

    // Back-to-back: second op issued in the first cycle with busy=0
    run_op(3'b000, 32'd6, 32'd7, 5, 32'd0, 32'd42, "b2b_mult");
    run_op(3'b001, 32'd3, 32'd5, 5, 32'd0, 32'd15, "b2b_multu");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog: a hang still reports and ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
